// File: rtl/pipe_stage_reg.sv
// Purpose : generic CPU pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying one
//           DATA_W-bit payload per beat over valid/ready, with synchronous flush and bubbles.
// Latency : 1 cycle in -> out when unstalled; sustained throughput 1 beat/cycle.
// Backpr. : SKID=0 -> in_ready = out_ready | ~out_valid (combinational path upstream);
//           SKID=1 -> 2-entry skid, in_ready registered, up to 2 beats held while stalled.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   flush      synchronous kill of every held beat and of any beat accepted this cycle
//   in_valid   upstream beat valid (must not depend on in_ready)
//   in_ready   this stage accepts a beat this cycle
//   in_data    upstream payload
//   out_valid  downstream beat valid
//   out_ready  downstream accepts a beat this cycle
//   out_data   downstream payload; RESET_DATA while in reset, BUBBLE_DATA when out_valid=0
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_reg #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_DATA  = '0,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter bit                SKID        = 1'b1,
    parameter int                STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [STAT_W-1:0] stall_cnt
);

    // Payload currently presented downstream; only meaningful while out_valid=1.
    logic [DATA_W-1:0] main_dat;

    // The reset term makes out_data show RESET_DATA the moment rst falls, without
    // waiting for a clock; otherwise an empty stage presents the bubble pattern.
    assign out_data = !rst      ? RESET_DATA  :
                      out_valid ? main_dat    :
                                  BUBBLE_DATA;

    // Saturating back-pressure counter; flush intentionally leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STAT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    generate
        if (SKID == 1'b0) begin : g_single
            // Single register. alive_q keeps in_ready low during reset and goes high
            // on the first clock edge after rst is released.
            logic              alive_q;
            logic              vld_q;
            logic [DATA_W-1:0] dat_q;

            assign in_ready  = alive_q & (out_ready | ~vld_q);
            assign out_valid = vld_q;
            assign main_dat  = dat_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    alive_q <= 1'b0;
                    vld_q   <= 1'b0;
                    dat_q   <= RESET_DATA;
                end else begin
                    alive_q <= 1'b1;
                    if (flush) begin
                        // A downstream accept this cycle still completes; nothing new is kept.
                        vld_q <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        // Covers both the empty case and the reload-while-draining case.
                        vld_q <= 1'b1;
                        dat_q <= in_data;
                    end else if (out_ready) begin
                        vld_q <= 1'b0;
                    end
                end
            end
        end else begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,    // nothing held
                ST_FULL  = 2'd1,    // main register valid
                ST_SKID  = 2'd2     // main and skid registers valid
            } state_t;

            state_t            state_q;
            logic              rdy_q;
            logic              vld_q;
            logic [DATA_W-1:0] dat_q;
            logic [DATA_W-1:0] skid_q;
            logic              in_acc;

            // rdy_q is registered, so upstream never sees out_ready combinationally.
            // The single skid slot absorbs the beat accepted in the cycle out_ready fell.
            assign in_ready  = rdy_q;
            assign out_valid = vld_q;
            assign main_dat  = dat_q;
            assign in_acc    = in_valid & rdy_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= ST_EMPTY;
                    rdy_q   <= 1'b0;
                    vld_q   <= 1'b0;
                    dat_q   <= RESET_DATA;
                    skid_q  <= RESET_DATA;
                end else if (flush) begin
                    // Held beats and this cycle's accepted beat are dropped; a
                    // downstream accept in this cycle has already completed.
                    state_q <= ST_EMPTY;
                    rdy_q   <= 1'b1;
                    vld_q   <= 1'b0;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            rdy_q <= 1'b1;
                            if (in_acc) begin
                                dat_q   <= in_data;
                                vld_q   <= 1'b1;
                                state_q <= ST_FULL;
                            end
                        end
                        ST_FULL: begin
                            rdy_q <= 1'b1;
                            if (in_acc && out_ready) begin
                                dat_q <= in_data;
                            end else if (in_acc) begin
                                // Downstream stalled: park the new beat and close the input.
                                skid_q  <= in_data;
                                rdy_q   <= 1'b0;
                                state_q <= ST_SKID;
                            end else if (out_ready) begin
                                vld_q   <= 1'b0;
                                state_q <= ST_EMPTY;
                            end
                        end
                        ST_SKID: begin
                            // Input is closed here, so only the drain side can move.
                            if (out_ready) begin
                                dat_q   <= skid_q;
                                rdy_q   <= 1'b1;
                                state_q <= ST_FULL;
                            end
                        end
                        default: begin
                            rdy_q   <= 1'b1;
                            vld_q   <= 1'b0;
                            state_q <= ST_EMPTY;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose : self-checking bench for pipe_stage_reg, SKID=1 (u_a) and SKID=0 (u_b) side by side.
// Latency : expected beats queued on accepted input, compared when the DUT delivers them.
// Backpr. : table rows drive out_ready low to exercise the skid, flush and saturation paths.
module tb_pipe_stage_reg;

    localparam logic [31:0] RST_D = 32'h0000_dead;
    localparam logic [31:0] BUB_D = 32'hbfc0_0000;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data   = '0;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [3:0]  a_stall;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [15:0] b_stall;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .RESET_DATA(RST_D), .BUBBLE_DATA(BUB_D), .SKID(1'b1), .STAT_W(4)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .RESET_DATA(RST_D), .BUBBLE_DATA(BUB_D), .SKID(1'b0), .STAT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sampled mid-cycle, so inputs/outputs reflect the coming posedge.
    always @(negedge clk) begin
        if (!rst) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (a_out_valid && out_ready) begin
                if (q_a.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_a: unexpected beat %h, expected none", a_out_data);
                end else begin
                    chk("sb_a", a_out_data, q_a.pop_front());
                end
            end
            if (!a_out_valid) chk("bubble_a", a_out_data, BUB_D);
            if (flush) q_a.delete();
            else if (in_valid && a_in_ready) q_a.push_back(in_data);

            if (b_out_valid && out_ready) begin
                if (q_b.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_b: unexpected beat %h, expected none", b_out_data);
                end else begin
                    chk("sb_b", b_out_data, q_b.pop_front());
                end
            end
            if (!b_out_valid) chk("bubble_b", b_out_data, BUB_D);
            if (flush) q_b.delete();
            else if (in_valid && b_in_ready) q_b.push_back(in_data);
        end
    end

    typedef struct {
        logic        iv;
        logic        fl;
        logic        ordy;
        logic [31:0] d;
        logic        exp_ov;
        logic        exp_ir;
        logic [31:0] exp_od;
        logic [3:0]  exp_st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic fl, input logic ordy, input logic [31:0] d,
                       input logic ov, input logic ir, input logic [31:0] od, input logic [3:0] st);
        vec_t v;
        v.iv = iv; v.fl = fl; v.ordy = ordy; v.d = d;
        v.exp_ov = ov; v.exp_ir = ir; v.exp_od = od; v.exp_st = st;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int es;

        // ---------------- reset state ----------------
        repeat (2) step();
        chk1("rst_ov_a", a_out_valid, 1'b0);
        chk1("rst_ir_a", a_in_ready, 1'b0);
        chk("rst_od_a", a_out_data, RST_D);
        chk("rst_st_a", 32'(a_stall), 32'd0);
        chk1("rst_ov_b", b_out_valid, 1'b0);
        chk1("rst_ir_b", b_in_ready, 1'b0);
        chk("rst_od_b", b_out_data, RST_D);
        rst = 1'b1;
        #1;
        chk1("rel_ir_pre_a", a_in_ready, 1'b0);
        chk1("rel_ir_pre_b", b_in_ready, 1'b0);
        step();
        chk1("rel_ir_a", a_in_ready, 1'b1);
        chk1("rel_ir_b", b_in_ready, 1'b1);

        // ---------------- streaming 1..100 ----------------
        out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            step();
            chk1("str_ov_a", a_out_valid, 1'b1);
            chk("str_od_a", a_out_data, 32'(i));
            chk1("str_ov_b", b_out_valid, 1'b1);
            chk("str_od_b", b_out_data, 32'(i));
        end
        chk("str_st_a", 32'(a_stall), 32'd0);

        // ---------------- bubble: 3 idle cycles ----------------
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("bub_ov_a", a_out_valid, 1'b0);
            chk("bub_od_a", a_out_data, BUB_D);
            chk1("bub_ov_b", b_out_valid, 1'b0);
            chk("bub_od_b", b_out_data, BUB_D);
        end

        // ---------------- table: back-pressure, flush (SKID=1 expectations) ----------------
        //   iv    fl    ordy  data  ov    ir    od     stall
        add(1'b1, 1'b0, 1'b1, 201, 1'b1, 1'b1, 201,   4'd0);
        add(1'b1, 1'b0, 1'b1, 202, 1'b1, 1'b1, 202,   4'd0);
        add(1'b1, 1'b0, 1'b1, 203, 1'b1, 1'b1, 203,   4'd0);
        add(1'b1, 1'b0, 1'b1, 204, 1'b1, 1'b1, 204,   4'd0);
        add(1'b1, 1'b0, 1'b1, 205, 1'b1, 1'b1, 205,   4'd0);
        add(1'b1, 1'b0, 1'b0, 206, 1'b1, 1'b0, 205,   4'd1);  // 206 parked in skid
        add(1'b1, 1'b0, 1'b0, 207, 1'b1, 1'b0, 205,   4'd2);  // input closed
        add(1'b1, 1'b0, 1'b1, 207, 1'b1, 1'b1, 206,   4'd2);  // skid -> main
        add(1'b1, 1'b0, 1'b1, 207, 1'b1, 1'b1, 207,   4'd2);
        add(1'b1, 1'b0, 1'b1, 208, 1'b1, 1'b1, 208,   4'd2);
        add(1'b0, 1'b0, 1'b1, 0,   1'b0, 1'b1, BUB_D, 4'd2);
        add(1'b1, 1'b0, 1'b1, 301, 1'b1, 1'b1, 301,   4'd2);
        add(1'b1, 1'b0, 1'b0, 302, 1'b1, 1'b0, 301,   4'd3);  // SKID state
        add(1'b1, 1'b1, 1'b0, 303, 1'b0, 1'b1, BUB_D, 4'd4);  // flush in SKID
        add(1'b0, 1'b0, 1'b1, 0,   1'b0, 1'b1, BUB_D, 4'd4);
        add(1'b1, 1'b0, 1'b1, 401, 1'b1, 1'b1, 401,   4'd4);
        add(1'b1, 1'b1, 1'b1, 402, 1'b0, 1'b1, BUB_D, 4'd4);  // 401 leaves, 402 dropped
        add(1'b1, 1'b0, 1'b1, 403, 1'b1, 1'b1, 403,   4'd4);
        add(1'b0, 1'b0, 1'b1, 0,   1'b0, 1'b1, BUB_D, 4'd4);

        foreach (tbl[r]) begin
            in_valid  = tbl[r].iv;
            flush     = tbl[r].fl;
            out_ready = tbl[r].ordy;
            in_data   = tbl[r].d;
            step();
            chk1($sformatf("tbl%0d_ov", r), a_out_valid, tbl[r].exp_ov);
            chk1($sformatf("tbl%0d_ir", r), a_in_ready, tbl[r].exp_ir);
            chk($sformatf("tbl%0d_od", r), a_out_data, tbl[r].exp_od);
            chk($sformatf("tbl%0d_st", r), 32'(a_stall), 32'(tbl[r].exp_st));
        end
        flush = 1'b0;

        // ---------------- stall counter saturation ----------------
        es = 4;
        in_valid  = 1'b1;
        in_data   = 32'd501;
        out_ready = 1'b1;
        step();
        chk("sat_load_a", a_out_data, 32'd501);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            es = (es < 15) ? es + 1 : 15;
            chk("sat_cnt", 32'(a_stall), 32'(es));
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_flush_cnt", 32'(a_stall), 32'd15);
        chk1("sat_flush_ov", a_out_valid, 1'b0);
        chk1("sat_flush_ir", a_in_ready, 1'b1);
        step();
        chk("sat_hold_cnt", 32'(a_stall), 32'd15);

        // ---------------- async reset mid-stream with beats held ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'd601;
        step();
        out_ready = 1'b0;
        in_data   = 32'd602;
        step();
        chk1("mid_skid_ir", a_in_ready, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk1("async_ov_a", a_out_valid, 1'b0);
        chk("async_od_a", a_out_data, RST_D);
        chk1("async_ir_a", a_in_ready, 1'b0);
        chk("async_st_a", 32'(a_stall), 32'd0);
        chk1("async_ov_b", b_out_valid, 1'b0);
        chk("async_od_b", b_out_data, RST_D);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        #1;
        chk1("rel2_ir_pre_a", a_in_ready, 1'b0);
        step();
        chk1("rel2_ir_a", a_in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd701;
        step();
        chk1("post_ov_a", a_out_valid, 1'b1);
        chk("post_od_a", a_out_data, 32'd701);
        chk("post_od_b", b_out_data, 32'd701);
        in_valid = 1'b0;
        step();
        chk1("post_drain_ov_a", a_out_valid, 1'b0);
        step();
        chk("sb_left_a", 32'(q_a.size()), 32'd0);
        chk("sb_left_b", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
